// File: rtl/layer_pkg.sv
// Shared types and arithmetic helpers for the layer MAC and truncation stages.
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } mac_state_t;

    // Accumulator wide enough that col full-scale products cannot overflow.
    function automatic int acc_width(input int datawidth, input int col);
        return (2 * datawidth) + $clog2(col);
    endfunction

    // Clamp a signed value to the range of an out_w-bit signed word (out_w <= 64).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                      input int out_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (val > max_v) begin
            return max_v;
        end else if (val < min_v) begin
            return min_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/layer_mac_if.sv
// Handshake and data bundle between the layer sequencer (master) and layer_mac (slave).
interface layer_mac_if #(
    parameter int row       = 30,
    parameter int col       = 30,
    parameter int datawidth = 11
);
    logic                            start;
    logic [col*datawidth-1:0]        layer_in;
    logic                            w_valid;
    logic                            w_ready;
    logic [row*datawidth-1:0]        w_data;
    logic                            trunc_done;
    logic [row*2*datawidth-1:0]      layer_out_pre;
    logic                            layer_done;

    modport master (
        output start, layer_in, w_valid, w_data, trunc_done,
        input  w_ready, layer_out_pre, layer_done
    );

    modport slave (
        input  start, layer_in, w_valid, w_data, trunc_done,
        output w_ready, layer_out_pre, layer_done
    );
endinterface

// File: rtl/mac_lane.sv
// One output row: signed multiplier, overflow-free accumulator and output saturator.
module mac_lane
    import layer_pkg::*;
#(
    parameter int datawidth = 11,
    parameter int col       = 30
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          enable,
    input  logic signed [datawidth-1:0]   x,
    input  logic signed [datawidth-1:0]   w,
    output logic signed [2*datawidth-1:0] sat_out
);
    localparam int OUT_W = 2 * datawidth;
    localparam int ACC_W = acc_width(datawidth, col);

    logic signed [OUT_W-1:0] prod_s;
    logic signed [ACC_W-1:0] acc_r;

    assign prod_s = OUT_W'(x) * OUT_W'(w);

    // Accumulate one product per accepted weight beat; clear when a layer starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clear) begin
            acc_r <= '0;
        end else if (enable) begin
            acc_r <= acc_r + ACC_W'(prod_s);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign sat_out = OUT_W'(sat_signed(64'(acc_r), OUT_W));

endmodule

// File: rtl/layer_mac.sv
// Row-parallel, column-serial matrix-vector MAC producing one layer's saturated
// full-precision sums, held until the truncation stage acknowledges them.
module layer_mac
    import layer_pkg::*;
#(
    parameter int row             = 30,
    parameter int col             = 30,
    parameter int datawidth       = 11,
    parameter int int_part_input  = 5,
    parameter int int_part_weight = 5
) (
    input  logic       clk,
    input  logic       rst_overall_n,
    layer_mac_if.slave bus
);
    localparam int OUT_W = 2 * datawidth;
    localparam int CNT_W = (col > 1) ? $clog2(col) : 1;

    // Integer-part widths only describe the number format; reject nonsense values.
    if (int_part_input > datawidth || int_part_weight > datawidth) begin : g_fmt_check
        $error("layer_mac: integer part wider than datawidth");
    end

    mac_state_t                     state_r;
    logic [CNT_W-1:0]               col_cnt_r;
    logic signed [datawidth-1:0]    x_r [col];
    logic                           w_ready_r;
    logic                           layer_done_r;
    logic [row*OUT_W-1:0]           out_r;

    logic                           clear_s;
    logic                           beat_s;
    logic signed [datawidth-1:0]    x_sel_s;
    logic signed [OUT_W-1:0]        lane_sat_s [row];

    assign clear_s = (state_r == IDLE) && bus.start;
    assign beat_s  = (state_r == ACCUM) && bus.w_valid;
    assign x_sel_s = x_r[col_cnt_r];

    for (genvar r = 0; r < row; r++) begin : g_lane
        mac_lane #(
            .datawidth (datawidth),
            .col       (col)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_overall_n),
            .clear   (clear_s),
            .enable  (beat_s),
            .x       (x_sel_s),
            .w       (bus.w_data[(row-1-r)*datawidth +: datawidth]),
            .sat_out (lane_sat_s[r])
        );
    end

    // Layer sequencer: input latch, column counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state_r      <= IDLE;
            col_cnt_r    <= '0;
            w_ready_r    <= 1'b0;
            layer_done_r <= 1'b0;
            out_r        <= '0;
            for (int i = 0; i < col; i++) begin
                x_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < col; i++) begin
                            x_r[i] <= bus.layer_in[(col-1-i)*datawidth +: datawidth];
                        end
                        col_cnt_r <= '0;
                        w_ready_r <= 1'b1;
                        state_r   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.w_valid) begin
                        if (col_cnt_r == CNT_W'(col - 1)) begin
                            col_cnt_r <= '0;
                            w_ready_r <= 1'b0;
                            state_r   <= DONE;
                        end else begin
                            col_cnt_r <= col_cnt_r + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    for (int r = 0; r < row; r++) begin
                        out_r[(row-1-r)*OUT_W +: OUT_W] <= lane_sat_s[r];
                    end
                    layer_done_r <= 1'b1;
                    state_r      <= HOLD;
                end
                HOLD: begin
                    if (bus.trunc_done) begin
                        layer_done_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    w_ready_r    <= 1'b0;
                    layer_done_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.w_ready       = w_ready_r;
    assign bus.layer_done    = layer_done_r;
    assign bus.layer_out_pre = out_r;

endmodule
